// File: rtl/mem_responder.sv
// Purpose : single-port memory responder with programmable wait states and a 4-phase Read/Write handshake.
// Latency : MemDone rises WAIT_STATES+2 edges after the request is sampled; MDataIn is valid at that point.
// Backpressure: requests are level-held; the initiator drops Read/Write after MemDone, and the next request is accepted one IDLE cycle later.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   Read, Write      level-held requests (Write wins if both are high)
//   MARVal, MDRVal   word address and write data, sampled only when a request is accepted
//   MDataIn          registered read data, held until the next read access
//   MemDone          registered completion flag, high while in DONE
//   MemBusy          high whenever the FSM is not IDLE
//   MemErr           registered out-of-range flag, high while in DONE
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag addresses with nonzero bits above
// ADDR_BITS (write suppressed, read returns 0, MemErr set). Without it, addresses wrap and MemErr is 0.

module mem_responder #(
  parameter int BITS        = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2   // legal range 0..15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Read,
  input  logic            Write,
  input  logic [BITS-1:0] MARVal,
  input  logic [BITS-1:0] MDRVal,
  output logic [BITS-1:0] MDataIn,
  output logic            MemDone,
  output logic            MemBusy,
  output logic            MemErr
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // The counter is loaded with WAIT_STATES-1 so that WAIT spans exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t          state_q;
  logic [3:0]      wait_cnt_q;
  logic [BITS-1:0] addr_q;
  logic [BITS-1:0] data_q;
  logic            write_q;
  logic [BITS-1:0] rdata_q;
  logic            done_q;
  logic            err_q;

  logic [BITS-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 oob;
  logic                 mem_we;

  assign idx = addr_q[ADDR_BITS-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = |addr_q[BITS-1:ADDR_BITS];
`else
  // Upper address bits are deliberately ignored: addresses wrap modulo the array depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[BITS-1:ADDR_BITS];
  assign oob            = 1'b0;
`endif

  // Reset wins over a write landing on the same edge; a write whose ACCESS edge
  // has already passed is in the array and is never undone.
  assign mem_we = (state_q == ACCESS) && write_q && !oob && !reset;

  // Array has no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Read || Write) begin
            addr_q  <= MARVal;
            data_q  <= MDRVal;
            write_q <= Write;   // Write has priority over a simultaneous Read
            if (WAIT_STATES > 0) begin
              state_q    <= WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end else begin
              state_q <= ACCESS;
            end
          end
        end

        WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= ACCESS;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end

        ACCESS: begin
          // Writes leave MDataIn untouched; out-of-range reads return zero.
          if (!write_q) begin
            rdata_q <= oob ? '0 : mem_q[idx];
          end
          err_q   <= oob;
          state_q <= DONE;
        end

        DONE: begin
          // MemDone is asserted one edge after entering DONE and drops on
          // the edge that sees the initiator release both requests.
          if (!Read && !Write) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MDataIn = rdata_q;
  assign MemDone = done_q;
  assign MemErr  = err_q;
  assign MemBusy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
// Latency: n/a (bench).
// Backpressure: bench plays the 4-phase initiator, holding requests until MemDone.

module tb_mem_responder;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        rd_v;
  logic [1:0]        wr_v;
  logic [1:0][31:0]  mar_v;
  logic [1:0][31:0]  mdr_v;
  logic [1:0][31:0]  dat_v;
  logic [1:0]        done_v;
  logic [1:0]        busy_v;
  logic [1:0]        err_v;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_responder #(.BITS(32), .ADDR_BITS(9), .WAIT_STATES(2)) dut_ws2 (
    .clk    (clk),
    .reset  (reset),
    .Read   (rd_v[0]),
    .Write  (wr_v[0]),
    .MARVal (mar_v[0]),
    .MDRVal (mdr_v[0]),
    .MDataIn(dat_v[0]),
    .MemDone(done_v[0]),
    .MemBusy(busy_v[0]),
    .MemErr (err_v[0])
  );

  mem_responder #(.BITS(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut_ws0 (
    .clk    (clk),
    .reset  (reset),
    .Read   (rd_v[1]),
    .Write  (wr_v[1]),
    .MARVal (mar_v[1]),
    .MDRVal (mdr_v[1]),
    .MDataIn(dat_v[1]),
    .MemDone(done_v[1]),
    .MemBusy(busy_v[1]),
    .MemErr (err_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full 4-phase transaction on instance s. Latency is counted in edges
  // after the sampling edge; 'hold' extra cycles keep the request up after MemDone.
  task automatic txn(input int s, input bit w, input bit r,
                     input logic [31:0] addr, input logic [31:0] data,
                     input bit scr, input int hold, input int exp_lat,
                     input logic [31:0] exp_dat, input bit chk_dat,
                     input logic exp_err, input string tag);
    int cnt;
    cnt      = 0;
    wr_v[s]  = w;
    rd_v[s]  = r;
    mar_v[s] = addr;
    mdr_v[s] = data;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (done_v[s] === 1'b1) break;
      if (scr) begin
        mar_v[s] = $urandom;
        mdr_v[s] = $urandom;
      end
    end
    chk({tag, "_lat"}, cnt - 1, exp_lat);
    chk({tag, "_busy"}, {31'd0, busy_v[s]}, 32'd1);
    chk({tag, "_err"}, {31'd0, err_v[s]}, {31'd0, exp_err});
    if (chk_dat) chk({tag, "_dat"}, dat_v[s], exp_dat);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_done"}, {31'd0, done_v[s]}, 32'd1);
      chk({tag, "_hold_busy"}, {31'd0, busy_v[s]}, 32'd1);
    end
    rd_v[s] = 1'b0;
    wr_v[s] = 1'b0;
    step();
    chk({tag, "_rel_done"}, {31'd0, done_v[s]}, 32'd0);
    chk({tag, "_rel_busy"}, {31'd0, busy_v[s]}, 32'd0);
    chk({tag, "_rel_err"}, {31'd0, err_v[s]}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rd_v  = '0;
    wr_v  = '0;
    mar_v = '0;
    mdr_v = '0;
    step();
    step();
    chk("rst_dat",  dat_v[0], 32'h0);
    chk("rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_err",  {31'd0, err_v[0]}, 32'd0);
    chk("rst_busy0", {31'd0, busy_v[1]}, 32'd0);
    reset = 1'b0;
    step();

    // Basic write then read, WAIT_STATES=2.
    txn(0, 1, 0, 32'h05, 32'hDEADBEEF, 0, 0, 4, 32'h0, 0, 1'b0, "wr05");
    txn(0, 0, 1, 32'h05, 32'h0, 0, 0, 4, 32'hDEADBEEF, 1, 1'b0, "rd05");

    // Dual request: write wins, MDataIn keeps the previous read value.
    txn(0, 1, 1, 32'h10, 32'h12345678, 0, 0, 4, 32'hDEADBEEF, 1, 1'b0, "dual");
    txn(0, 0, 1, 32'h10, 32'h0, 0, 0, 4, 32'h12345678, 1, 1'b0, "rd10");

    // Inputs scrambled every cycle after sampling.
    txn(0, 1, 0, 32'h30, 32'h0BADF00D, 1, 0, 4, 32'h0, 0, 1'b0, "wr30scr");
    txn(0, 0, 1, 32'h30, 32'h0, 1, 0, 4, 32'h0BADF00D, 1, 1'b0, "rd30scr");

    // Reset during WAIT aborts a pending write.
    txn(0, 1, 0, 32'h20, 32'hAAAA5555, 0, 0, 4, 32'h0, 0, 1'b0, "wr20");
    wr_v[0]  = 1'b1;
    mar_v[0] = 32'h20;
    mdr_v[0] = 32'h11111111;
    step();
    chk("abort_busy_wait", {31'd0, busy_v[0]}, 32'd1);
    step();
    reset   = 1'b1;
    wr_v[0] = 1'b0;
    step();
    chk("abort_dat",  dat_v[0], 32'h0);
    chk("abort_done", {31'd0, done_v[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("abort_err",  {31'd0, err_v[0]}, 32'd0);
    reset = 1'b0;
    step();
    txn(0, 0, 1, 32'h20, 32'h0, 0, 0, 4, 32'hAAAA5555, 1, 1'b0, "rd20");

    // Upper address bits: out of range with bounds check, wrap otherwise.
    txn(0, 1, 0, 32'h205, 32'hCAFEF00D, 0, 0, 4, 32'h0, 0, BC, "wr205");
    txn(0, 0, 1, 32'h005, 32'h0, 0, 0, 4, BC ? 32'hDEADBEEF : 32'hCAFEF00D, 1, 1'b0, "rd005");
    txn(0, 0, 1, 32'h205, 32'h0, 0, 0, 4, BC ? 32'h0 : 32'hCAFEF00D, 1, BC, "rd205");

    // WAIT_STATES=0: two-edge latency, MemDone held while Read is held.
    txn(1, 1, 0, 32'h05, 32'h600DCAFE, 0, 0, 2, 32'h0, 0, 1'b0, "ws0_wr05");
    txn(1, 0, 1, 32'h05, 32'h0, 0, 3, 2, 32'h600DCAFE, 1, 1'b0, "ws0_rd05");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter BITS, default 32: width of address and data words.
REQ-002 Parameter ADDR_BITS, default 9: index width; array depth is 2**ADDR_BITS words.
REQ-003 Parameter WAIT_STATES, default 2: wait cycles inserted before each array access; the legal range is 0..15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Read  input  1  read request, level-held by the initiator.
REQ-007 Write  input  1  write request, level-held by the initiator.
REQ-008 MARVal  input  BITS  word address.
REQ-009 MDRVal  input  BITS  write data.
REQ-010 MDataIn  output  BITS  read data returned to the initiator; registered.
REQ-011 MemDone  output  1  access complete; registered.
REQ-012 MemBusy  output  1  high whenever state is not IDLE.
REQ-013 MemErr  output  1  out-of-range access flag; registered.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, ACCESS and DONE.
REQ-015 In IDLE, if Read or Write is high at edge N, the block SHALL latch MARVal, MDRVal and the operation type.
- Next state after that edge: WAIT if WAIT_STATES>0, else ACCESS.
REQ-016 If Read and Write are both high at the sampling edge, Write SHALL take priority, and Read SHALL be ignored for that transaction.
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles, counted by an internal down-counter, then go to ACCESS.
REQ-018 ACCESS SHALL last one cycle.
- Write: mem[addr] <= latched data.
- Read: MDataIn <= mem[addr].
- Next state: DONE.
REQ-019 The array index SHALL be the latched address bits [ADDR_BITS-1:0].
REQ-020 MemDone SHALL be high from edge N+WAIT_STATES+2 for as long as the state is DONE.
REQ-021 DONE SHALL return to IDLE on the first edge at which Read and Write are both low (4-phase handshake).
- MemDone drops on that same edge.
- A new request is not accepted in that cycle.
REQ-022 MDataIn SHALL hold its value until the next read ACCESS; write transactions SHALL NOT alter it.
REQ-023 Latched address and data SHALL be insensitive to changes on MARVal or MDRVal after the sampling edge.
REQ-024 Back-to-back transactions SHALL be separated by at least one IDLE cycle.

Reset
REQ-025 While reset is high at an edge, the block SHALL force the following values:
- state = IDLE, wait counter = 0;
- MDataIn = 0, MemDone = 0, MemErr = 0, MemBusy = 0.
REQ-026 Reset SHALL NOT clear the memory array.
REQ-027 Reset asserted during WAIT SHALL abort the transaction, and no write is committed.
REQ-028 A write that has reached ACCESS before reset asserts SHALL remain committed.
REQ-029 Reset SHALL take priority over any simultaneous request.

Configuration
REQ-030 When macro MEM_BOUNDS_CHECK_EN is defined, a latched address with any nonzero bit in [BITS-1:ADDR_BITS] SHALL be treated as out of range:
- a write is suppressed;
- a read returns 0 on MDataIn;
- MemErr is high for the duration of DONE.
REQ-031 When MEM_BOUNDS_CHECK_EN is undefined, upper address bits SHALL be ignored (addresses wrap modulo 2**ADDR_BITS), and MemErr SHALL be tied to 0.

Verification
REQ-032 Write MARVal=0x05, MDRVal=0xDEADBEEF, WAIT_STATES=2, then a read of 0x05 -> MemDone rises 4 edges after each sampling edge; MDataIn=0xDEADBEEF.
REQ-033 WAIT_STATES=0, read of 0x05 -> MemDone rises 2 edges after the sampling edge.
- Hold Read high for 3 extra cycles -> MemDone stays high and MemBusy=1.
- Drop Read -> MemDone=0 and IDLE on the next edge.
REQ-034 Read and Write both high, MARVal=0x10, MDRVal=0x12345678 -> the write is performed; a later read of 0x10 returns 0x12345678, and MDataIn is unchanged by the dual request.
REQ-035 Write 0xAAAA5555 to 0x20; start a write of 0x11111111 to 0x20; assert reset during WAIT -> all outputs 0, state IDLE; a read of 0x20 returns 0xAAAA5555.
REQ-036 Write 0xCAFEF00D to MARVal=0x205 (ADDR_BITS=9), then read 0x005.
- With MEM_BOUNDS_CHECK_EN: MemErr=1 during the write DONE; the read returns the prior contents of 0x005.
- Without MEM_BOUNDS_CHECK_EN: the read returns 0xCAFEF00D and MemErr stays 0.
REQ-037 Change MARVal and MDRVal every cycle during WAIT -> the access uses the values latched at the sampling edge.
